zap_store_formatter: RTL and testbench
======================================

# zap_store_formatter

Outbound memory-request formatter between the ALU stage and the data cache: the store-side counterpart of the memory stage's load-data rotator. It accepts a load/store request with address, size flags and source data. It drives the cache bus with:
- replicated write data in all byte lanes,
- byte-lane enables derived from address and size,
- a word-aligned address.

A two-entry buffer (bus register plus skid register) holds requests across cache back-pressure.

## Interface
- No parameters.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_clear  in  1  pipeline flush from writeback.
- i_valid  in  1  upstream request valid.
- o_ready  out  1  request accepted when i_valid & o_ready.
- i_address  in  32  byte address.
- i_store_data  in  32  register value to store.
- i_load  in  1  1 = load, 0 = store.
- i_sbyte, i_ubyte, i_shalf, i_uhalf  in  1 each  access size; all 0 = word.
- o_cyc, o_stb  out  1  bus request, both asserted together.
- o_we  out  1  write enable (= !load).
- o_adr  out  32  {addr[31:2], 2'b00}.
- o_sel  out  4  byte-lane enables.
- o_dat  out  32  formatted write data.
- i_ack  in  1  cache completion.
- i_fault  in  2  fault code, valid with i_ack.
- o_done  out  1  one-cycle pulse after a completed, non-flushed transfer.
- o_fault  out  2  fault captured with the last ack; held until the next ack.

## Operation
- Formatting is a pure function of size and addr[1:0], applied at acceptance.
  - Byte (sbyte or ubyte): dat = {4{data[7:0]}}; sel = 4'b0001 << addr[1:0].
  - Half (shalf or uhalf): dat = {2{data[15:0]}}; sel = addr[1] ? 4'b1100 : 4'b0011. addr[0] is ignored.
  - Word: dat = data, not rotated; sel = 4'b1111 regardless of addr[1:0].
  - Size flag priority: ubyte > sbyte > shalf > uhalf > word.
  - Loads: same sel; dat = 0; we = 0.
- FSM states: IDLE (bus idle), BUSY (one transfer on the bus), FULL (transfer on the bus plus one entry in skid).
  - IDLE: accept -> load bus register -> BUSY.
  - BUSY, ack with accept -> new request goes straight into the bus register; stay BUSY (back-to-back transfers).
  - BUSY, ack without accept -> IDLE.
  - BUSY, accept without ack -> write skid -> FULL.
  - FULL, ack -> skid moves to the bus register -> BUSY.
- o_ready = (state != FULL).
- Bus signals stay stable from stb rise until the cycle containing ack.
- i_clear:
  - Drops the skid entry and blocks acceptance that cycle.
  - An in-flight bus transfer is not aborted; it runs to ack, then goes to IDLE with o_done suppressed (o_fault still updates).
  - Clear in IDLE has no effect.
- i_ack while stb is low is ignored.

## Timing
- Accept in cycle N -> o_stb high in N+1.
- Ack in cycle M -> o_done high in M+1, o_fault valid from M+1.
- Ack in the same cycle stb first rises is legal: single-cycle transfer.
- Sustained throughput is 1 transfer/cycle when i_ack is tied high.
- Reset values: state IDLE; o_cyc, o_stb, o_we, o_done = 0; o_adr, o_dat = 0; o_sel = 0; o_fault = 0; o_ready = 1 from the cycle after reset.
- Reset mid-transfer drops bus request immediately; the cache owns recovery.
- Reset has priority over i_clear, and i_clear has priority over accept.

## Structure
- Shared package zap_mem_pkg:
  - size enum (BYTE, HALF, WORD)
  - request struct {adr, dat, sel, we}
  - FSM state enum
  - fault code constants
- Sub-module zap_store_lane_fmt: combinational size/addr -> {dat, sel}. Instantiated once, in front of both bus and skid registers.

## Test plan
- Byte store, addr 0x1003, data 0xAABBCC5A -> adr 0x1000, sel 4'b1000, dat 0x5A5A5A5A, we 1.
- Half store, addr 0x2002, data 0x1234BEEF -> sel 4'b1100, dat 0xBEEFBEEF. Repeat with addr 0x2003 -> same sel.
- Word load, addr 0x3001 -> adr 0x3000, sel 4'b1111, we 0, dat 0.
- Three back-to-back requests with i_ack held low 3 cycles:
  - o_ready drops after the 2nd is accepted.
  - 3rd waits.
  - All complete in order after ack.
  - Three o_done pulses.
- i_clear asserted while FULL -> skid entry never appears on the bus; in-flight transfer completes with no o_done; state IDLE.
- Ack with i_fault=2'b01 -> o_fault=01 next cycle, held through the next fault-free ack, then returns to 00.

Source files
------------

// File: rtl/zap_mem_pkg.sv
// zap_mem_pkg: shared types and constants for the data-cache request path
package zap_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FULL} state_t;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } req_t;
  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_ABORT = 2'b01;
  localparam logic [1:0] FAULT_PERM  = 2'b10;
  localparam logic [1:0] FAULT_BUS   = 2'b11;
  function automatic size_t size_decode(input logic ub, input logic sb, input logic sh, input logic uh);
    return (ub | sb) ? SZ_BYTE : (sh | uh) ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/zap_store_lane_fmt.sv
// zap_store_lane_fmt: replicates store data across lanes and derives byte enables
module zap_store_lane_fmt
  import zap_mem_pkg::*;
(
  input  size_t       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_load,
  input  logic [31:0] i_data,
  output logic [31:0] o_dat,
  output logic [3:0]  o_sel
);
  // lane enables follow size and low address bits; loads carry no data
  always_comb begin
    o_sel = i_size == SZ_BYTE ? 4'b0001 << i_addr_lo :
            i_size == SZ_HALF ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_dat = i_load ? '0 :
            i_size == SZ_BYTE ? {4{i_data[7:0]}} :
            i_size == SZ_HALF ? {2{i_data[15:0]}} : i_data;
  end
endmodule

// File: rtl/zap_store_formatter.sv
// zap_store_formatter: formats load/store requests onto the cache bus with a two-entry buffer
module zap_store_formatter
  import zap_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_address,
  input  logic [31:0] i_store_data,
  input  logic        i_load,
  input  logic        i_sbyte,
  input  logic        i_ubyte,
  input  logic        i_shalf,
  input  logic        i_uhalf,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [31:0] o_adr,
  output logic [3:0]  o_sel,
  output logic [31:0] o_dat,
  input  logic        i_ack,
  input  logic [1:0]  i_fault,
  output logic        o_done,
  output logic [1:0]  o_fault
);
  state_t      state_q, state_d;
  req_t        bus_q, bus_d, skid_q, skid_d, fmt;
  logic        done_q, done_d, flush_q, flush_d, ack, accept;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] fmt_dat;
  logic [3:0]  fmt_sel;

  zap_store_lane_fmt u_fmt (
    .i_size   (size_decode(i_ubyte, i_sbyte, i_shalf, i_uhalf)),
    .i_addr_lo(i_address[1:0]),
    .i_load   (i_load),
    .i_data   (i_store_data),
    .o_dat    (fmt_dat),
    .o_sel    (fmt_sel)
  );

  assign fmt     = '{adr: {i_address[31:2], 2'b00}, dat: fmt_dat, sel: fmt_sel, we: ~i_load};
  assign o_ready = state_q != ST_FULL;
  assign o_cyc   = state_q != ST_IDLE;
  assign o_stb   = state_q != ST_IDLE;
  assign o_we    = bus_q.we;
  assign o_adr   = bus_q.adr;
  assign o_sel   = bus_q.sel;
  assign o_dat   = bus_q.dat;
  assign o_done  = done_q;
  assign o_fault = fault_q;

  // next-state: a flush lets the bus transfer finish but silences its done pulse
  always_comb begin
    ack     = i_ack & (state_q != ST_IDLE);
    accept  = i_valid & o_ready & ~i_clear;
    state_d = state_q;
    bus_d   = bus_q;
    skid_d  = skid_q;
    done_d  = ack & ~flush_q & ~i_clear;
    fault_d = ack ? i_fault : fault_q;
    flush_d = ~ack & (flush_q | (i_clear & (state_q != ST_IDLE)));
    case (state_q)
      ST_IDLE: if (accept) begin
        bus_d   = fmt;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (accept & ack) bus_d = fmt;
      else if (accept) begin
        skid_d  = fmt;
        state_d = ST_FULL;
      end
      else if (ack) state_d = ST_IDLE;
      ST_FULL: if (i_clear) state_d = ack ? ST_IDLE : ST_BUSY;
      else if (ack) begin
        bus_d   = skid_q;
        state_d = ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, bus/skid registers and completion status
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      bus_q   <= '0;
      skid_q  <= '0;
      done_q  <= 1'b0;
      flush_q <= 1'b0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      skid_q  <= skid_d;
      done_q  <= done_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_zap_store_formatter.sv
// tb_zap_store_formatter: directed self-checking bench for zap_store_formatter
module tb_zap_store_formatter;
  logic        i_clk, i_reset, i_clear, i_valid, o_ready;
  logic [31:0] i_address, i_store_data, o_adr, o_dat;
  logic        i_load, i_sbyte, i_ubyte, i_shalf, i_uhalf;
  logic        o_cyc, o_stb, o_we, i_ack, o_done;
  logic [3:0]  o_sel;
  logic [1:0]  i_fault, o_fault;
  int checks = 0, errors = 0;
  logic [31:0] r_adr, r_dat;
  logic [3:0]  r_sel;
  logic        r_we, r_stb, r_done;
  logic [1:0]  r_flt;
  int          n_done;

  zap_store_formatter dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_address(i_address), .i_store_data(i_store_data), .i_load(i_load),
    .i_sbyte(i_sbyte), .i_ubyte(i_ubyte), .i_shalf(i_shalf), .i_uhalf(i_uhalf),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_adr(o_adr), .o_sel(o_sel), .o_dat(o_dat),
    .i_ack(i_ack), .i_fault(i_fault), .o_done(o_done), .o_fault(o_fault)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  // sz is {ubyte, sbyte, shalf, uhalf}; ack is raised in the same cycle stb first rises
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic ld, input logic [3:0] sz,
                      input logic [1:0] f);
    @(negedge i_clk);
    i_valid = 1; i_address = a; i_store_data = d; i_load = ld;
    {i_ubyte, i_sbyte, i_shalf, i_uhalf} = sz;
    @(negedge i_clk);
    i_valid = 0; r_adr = o_adr; r_dat = o_dat; r_sel = o_sel; r_we = o_we; r_stb = o_stb;
    i_ack = 1; i_fault = f;
    @(negedge i_clk);
    i_ack = 0; i_fault = 0; r_done = o_done; r_flt = o_fault;
  endtask

  task automatic test_reset;
    i_reset = 1; i_clear = 0; i_valid = 0; i_ack = 0; i_fault = 0; i_load = 0;
    i_address = 0; i_store_data = 0; {i_ubyte, i_sbyte, i_shalf, i_uhalf} = 0;
    repeat (2) @(negedge i_clk);
    checks++; if ({o_cyc, o_stb, o_we, o_done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {o_cyc, o_stb, o_we, o_done}); end
    checks++; if ({o_adr, o_dat, o_sel, o_fault} !== 70'd0) begin errors++; $display("FAIL reset_bus got adr %h dat %h sel %b fault %b exp all zero", o_adr, o_dat, o_sel, o_fault); end
    i_reset = 0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
  endtask

  task automatic test_byte_store;
    xfer(32'h1003, 32'hAABBCC5A, 0, 4'b0100, 2'b00);
    checks++; if (r_stb !== 1'b1 || r_adr !== 32'h1000) begin errors++; $display("FAIL byte_adr got stb %b adr %h exp 1 00001000", r_stb, r_adr); end
    checks++; if (r_sel !== 4'b1000) begin errors++; $display("FAIL byte_sel got %b exp 1000", r_sel); end
    checks++; if (r_dat !== 32'h5A5A5A5A || r_we !== 1'b1) begin errors++; $display("FAIL byte_dat got %h we %b exp 5a5a5a5a 1", r_dat, r_we); end
    checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL byte_done got %b exp 1", r_done); end
    xfer(32'h1001, 32'h00000077, 0, 4'b1000, 2'b00);
    checks++; if (r_sel !== 4'b0010 || r_dat !== 32'h77777777) begin errors++; $display("FAIL ubyte got sel %b dat %h exp 0010 77777777", r_sel, r_dat); end
    xfer(32'h1002, 32'h12345678, 0, 4'b1010, 2'b00);
    checks++; if (r_sel !== 4'b0100 || r_dat !== 32'h78787878) begin errors++; $display("FAIL size_prio got sel %b dat %h exp 0100 78787878", r_sel, r_dat); end
  endtask

  task automatic test_half_store;
    xfer(32'h2002, 32'h1234BEEF, 0, 4'b0010, 2'b00);
    checks++; if (r_sel !== 4'b1100 || r_dat !== 32'hBEEFBEEF || r_adr !== 32'h2000) begin errors++; $display("FAIL half2 got sel %b dat %h adr %h exp 1100 beefbeef 00002000", r_sel, r_dat, r_adr); end
    xfer(32'h2003, 32'h1234BEEF, 0, 4'b0001, 2'b00);
    checks++; if (r_sel !== 4'b1100 || r_dat !== 32'hBEEFBEEF) begin errors++; $display("FAIL half3 got sel %b dat %h exp 1100 beefbeef", r_sel, r_dat); end
    xfer(32'h2001, 32'h1234BEEF, 0, 4'b0010, 2'b00);
    checks++; if (r_sel !== 4'b0011) begin errors++; $display("FAIL half1 got sel %b exp 0011", r_sel); end
  endtask

  task automatic test_word;
    xfer(32'h3001, 32'hDEADBEEF, 1, 4'b0000, 2'b00);
    checks++; if (r_adr !== 32'h3000 || r_sel !== 4'b1111) begin errors++; $display("FAIL wload_adr got adr %h sel %b exp 00003000 1111", r_adr, r_sel); end
    checks++; if (r_we !== 1'b0 || r_dat !== 32'h0) begin errors++; $display("FAIL wload_dat got we %b dat %h exp 0 00000000", r_we, r_dat); end
    xfer(32'h4002, 32'h11223344, 0, 4'b0000, 2'b00);
    checks++; if (r_sel !== 4'b1111 || r_dat !== 32'h11223344 || r_we !== 1'b1) begin errors++; $display("FAIL wstore got sel %b dat %h we %b exp 1111 11223344 1", r_sel, r_dat, r_we); end
  endtask

  task automatic test_back_to_back;
    n_done = 0;
    @(negedge i_clk);
    i_valid = 1; i_address = 32'h100; i_store_data = 32'hA; i_load = 0; {i_ubyte, i_sbyte, i_shalf, i_uhalf} = 0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1 || o_adr !== 32'h100) begin errors++; $display("FAIL b2b_first got ready %b adr %h exp 1 00000100", o_ready, o_adr); end
    i_address = 32'h104; i_store_data = 32'hB;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b0 || o_adr !== 32'h100) begin errors++; $display("FAIL b2b_full got ready %b adr %h exp 0 00000100", o_ready, o_adr); end
    i_address = 32'h108; i_store_data = 32'hC;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b0 || o_adr !== 32'h100 || o_dat !== 32'hA) begin errors++; $display("FAIL b2b_hold got ready %b adr %h dat %h exp 0 00000100 0000000a", o_ready, o_adr, o_dat); end
    i_ack = 1;
    @(negedge i_clk);
    n_done += int'(o_done);
    checks++; if (o_adr !== 32'h104 || o_dat !== 32'hB || o_ready !== 1'b1) begin errors++; $display("FAIL b2b_second got adr %h dat %h ready %b exp 00000104 0000000b 1", o_adr, o_dat, o_ready); end
    @(negedge i_clk);
    n_done += int'(o_done);
    checks++; if (o_adr !== 32'h108 || o_dat !== 32'hC) begin errors++; $display("FAIL b2b_third got adr %h dat %h exp 00000108 0000000c", o_adr, o_dat); end
    i_valid = 0;
    @(negedge i_clk);
    n_done += int'(o_done);
    checks++; if (o_stb !== 1'b0) begin errors++; $display("FAIL b2b_idle got stb %b exp 0", o_stb); end
    i_ack = 0;
    @(negedge i_clk);
    n_done += int'(o_done);
    checks++; if (n_done != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", n_done); end
  endtask

  task automatic test_clear;
    @(negedge i_clk);
    i_valid = 1; i_address = 32'h200; i_store_data = 32'h22; i_load = 0; {i_ubyte, i_sbyte, i_shalf, i_uhalf} = 0;
    @(negedge i_clk);
    i_address = 32'h204; i_store_data = 32'h33;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL clr_full got ready %b exp 0", o_ready); end
    i_valid = 0; i_clear = 1;
    @(negedge i_clk);
    i_clear = 0;
    checks++; if (o_stb !== 1'b1 || o_adr !== 32'h200 || o_ready !== 1'b1) begin errors++; $display("FAIL clr_inflight got stb %b adr %h ready %b exp 1 00000200 1", o_stb, o_adr, o_ready); end
    @(negedge i_clk);
    checks++; if (o_adr !== 32'h200) begin errors++; $display("FAIL clr_stable got adr %h exp 00000200", o_adr); end
    i_ack = 1;
    @(negedge i_clk);
    i_ack = 0;
    checks++; if (o_done !== 1'b0 || o_stb !== 1'b0) begin errors++; $display("FAIL clr_nodone got done %b stb %b exp 0 0", o_done, o_stb); end
    @(negedge i_clk);
    checks++; if (o_stb !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL clr_idle got stb %b done %b ready %b exp 0 0 1", o_stb, o_done, o_ready); end
    i_valid = 1; i_clear = 1; i_address = 32'h300;
    @(negedge i_clk);
    i_valid = 0; i_clear = 0;
    checks++; if (o_stb !== 1'b0) begin errors++; $display("FAIL clr_blocks_accept got stb %b exp 0", o_stb); end
  endtask

  task automatic test_fault;
    xfer(32'h500, 32'h1, 0, 4'b0000, 2'b01);
    checks++; if (r_flt !== 2'b01 || r_done !== 1'b1) begin errors++; $display("FAIL fault_capture got fault %b done %b exp 01 1", r_flt, r_done); end
    @(negedge i_clk);
    i_ack = 1; i_fault = 2'b11;
    @(negedge i_clk);
    i_ack = 0; i_fault = 0;
    checks++; if (o_fault !== 2'b01 || o_done !== 1'b0) begin errors++; $display("FAIL idle_ack got fault %b done %b exp 01 0", o_fault, o_done); end
    xfer(32'h504, 32'h2, 0, 4'b0000, 2'b00);
    checks++; if (r_flt !== 2'b00) begin errors++; $display("FAIL fault_clear got %b exp 00", r_flt); end
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    i_valid = 1; i_address = 32'h600; i_load = 0;
    @(negedge i_clk);
    i_valid = 0; i_reset = 1;
    @(negedge i_clk);
    checks++; if (o_stb !== 1'b0 || o_cyc !== 1'b0) begin errors++; $display("FAIL reset_mid got stb %b cyc %b exp 0 0", o_stb, o_cyc); end
    i_reset = 0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b exp 1", o_ready); end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_store();
    test_word();
    test_back_to_back();
    test_clear();
    test_fault();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
